// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter states, default baud divisor and block layout.
// Byte k of a block occupies bits [8k+7:8k]; byte 0 is sent/received first, LSB first.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    GAP,
    NEXT
  } tx_state_t;

  localparam int UART_CLKS_PER_BIT = 2534;
  localparam int UART_DATA_BITS    = 8;
  localparam int BLOCK_BYTES       = 8;

  function automatic logic [UART_DATA_BITS-1:0] block_byte(
    input logic [UART_DATA_BITS*BLOCK_BYTES-1:0] blk,
    input int                                    k
  );
    return blk[UART_DATA_BITS*k +: UART_DATA_BITS];
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Divider: one-cycle bit_tick every CLKS_PER_BIT enabled cycles; clear holds count at 0.
// Tick is combinational from the count register, so it is valid in the same cycle.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic bit_tick
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [W-1:0] cnt;

  assign bit_tick = en && !clr && (cnt == W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || bit_tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_block_tx.sv
// Sends a NUM_BYTES block as back-to-back 8N1 frames; tx falls one edge after start, done after last stop/gap.
// start is only accepted when idle or in the done cycle; otherwise it is dropped.
module uart_block_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int NUM_BYTES    = BLOCK_BYTES,
  parameter int GAP_BITS     = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [UART_DATA_BITS*NUM_BYTES-1:0] data_in,
  output logic                                tx,
  output logic                                busy,
  output logic                                done,
  output logic [2:0]                          byte_idx
);

  localparam int BW      = UART_DATA_BITS * NUM_BYTES;
  localparam int GAP_DIV = (GAP_BITS > 0) ? GAP_BITS : 1;

  tx_state_t                 state;
  logic [BW-1:0]             blk;
  logic [UART_DATA_BITS-1:0] sh;
  logic [2:0]                bit_cnt;
  logic                      bit_tick;
  logic                      gap_tick;
  logic                      last;
  logic                      frame_end;
  logic                      accept;

  assign last   = (byte_idx == 3'(NUM_BYTES - 1));
  assign accept = start && ((state == IDLE) || (state == NEXT && last));

  // The timer keeps running through a mid-block NEXT so the next start bit begins at count 1.
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .en       (state != IDLE),
    .clr      ((state == IDLE) || (state == NEXT && last)),
    .bit_tick (bit_tick)
  );

  uart_bit_timer #(.CLKS_PER_BIT(GAP_DIV)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .en       ((state == GAP) && bit_tick),
    .clr      (state != GAP),
    .bit_tick (gap_tick)
  );

  assign frame_end = bit_tick && (((state == STOP) && (GAP_BITS == 0)) ||
                                  ((state == GAP) && gap_tick));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      blk      <= '0;
      sh       <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      byte_idx <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        blk      <= data_in;
        sh       <= data_in[UART_DATA_BITS-1:0];
        byte_idx <= '0;
        busy     <= 1'b1;
        tx       <= 1'b0;
        state    <= START;
      end else begin
        case (state)
          IDLE: begin
            tx <= 1'b1;
          end
          START: begin
            if (bit_tick) begin
              state   <= DATA;
              bit_cnt <= '0;
              tx      <= sh[0];
              sh      <= sh >> 1;
            end
          end
          DATA: begin
            if (bit_tick) begin
              if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
                state <= STOP;
                tx    <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                tx      <= sh[0];
                sh      <= sh >> 1;
              end
            end
          end
          STOP, GAP: begin
            if (frame_end) begin
              state <= NEXT;
              if (last) begin
                done <= 1'b1;
                busy <= 1'b0;
              end else begin
                // Next start bit goes out during NEXT so frame spacing stays exact.
                tx <= 1'b0;
              end
            end else if (state == STOP && bit_tick) begin
              state <= GAP;
            end
          end
          NEXT: begin
            if (last) begin
              byte_idx <= '0;
              state    <= IDLE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              blk      <= blk >> UART_DATA_BITS;
              sh       <= blk[2*UART_DATA_BITS-1:UART_DATA_BITS];
              state    <= START;
            end
          end
          default: begin
            state <= IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_block_tx.sv
// Directed bench for uart_block_tx: frame decode, timing, ignored/back-to-back starts, async reset, gap bits.
module tb_uart_block_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [63:0] data_in = '0;
  logic        tx_a, busy_a, done_a;
  logic        tx_b, busy_b, done_b;
  logic [2:0]  idx_a, idx_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_block_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(8), .GAP_BITS(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .data_in(data_in),
    .tx(tx_a), .busy(busy_a), .done(done_a), .byte_idx(idx_a)
  );

  uart_block_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(8), .GAP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .data_in(data_in),
    .tx(tx_b), .busy(busy_b), .done(done_b), .byte_idx(idx_b)
  );

  task automatic check(input string tag, input string what, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s %s: got %0h expected %0h", tag, what, got, exp);
    end
  endtask

  task automatic set_start(input bit g, input logic v);
    if (g) start_b = v;
    else   start_a = v;
  endtask

  // Entered with start already driven high; first sample is the cycle after tx falls.
  task automatic run_block(input bit g, input logic [63:0] d, input int gap,
                           input int inj, input logic [63:0] inj_d,
                           input bit chain, input logic [63:0] chain_d, input string tag);
    int          per;
    int          abs_s;
    int          b;
    logic [15:0] obs;
    logic [15:0] exp;
    logic        first;
    logic        t;
    bit          stable;
    bit          busy_ok;
    per     = (10 + gap) * 4;
    busy_ok = 1'b1;
    first   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      obs    = '1;
      exp    = '1;
      exp[0] = 1'b0;
      exp[8:1] = d[8*k +: 8];
      stable = 1'b1;
      for (int s = 0; s < per; s++) begin
        @(negedge clk);
        abs_s = k * per + s;
        if (abs_s == 0) set_start(g, 1'b0);
        if (abs_s == inj) begin
          data_in = inj_d;
          set_start(g, 1'b1);
        end
        if (abs_s == inj + 1) set_start(g, 1'b0);
        t = g ? tx_b : tx_a;
        b = s / 4;
        if (s % 4 == 0) first = t;
        else if (t !== first) stable = 1'b0;
        if (s % 4 == 2) obs[b] = t;
        if ((g ? busy_b : busy_a) !== 1'b1 || (g ? done_b : done_a) !== 1'b0) busy_ok = 1'b0;
        if (s == per / 2) check(tag, $sformatf("byte_idx[%0d]", k), g ? idx_b : idx_a, k);
      end
      check(tag, $sformatf("frame[%0d]", k), obs, exp);
      check(tag, $sformatf("bit_stable[%0d]", k), stable, 1);
    end
    check(tag, "busy_high_no_done", busy_ok, 1);
    @(negedge clk);
    check(tag, "done_pulse", g ? done_b : done_a, 1);
    check(tag, "busy_low_at_done", g ? busy_b : busy_a, 0);
    if (chain) begin
      data_in = chain_d;
      set_start(g, 1'b1);
    end else begin
      @(negedge clk);
      check(tag, "done_cleared", g ? done_b : done_a, 0);
      check(tag, "idle_tx", g ? tx_b : tx_a, 1);
      check(tag, "idle_idx", g ? idx_b : idx_a, 0);
    end
  endtask

  initial begin
    bit idle_ok;

    // Reset state
    @(negedge clk);
    check("reset", "tx_a", tx_a, 1);
    check("reset", "busy_a", busy_a, 0);
    check("reset", "done_a", done_a, 0);
    check("reset", "idx_a", idx_a, 0);
    check("reset", "tx_b", tx_b, 1);
    rst = 1'b0;

    // Idle line
    idle_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) idle_ok = 1'b0;
    end
    check("idle", "line_quiet", idle_ok, 1);

    // Basic block
    data_in = 64'h0123456789ABCDEF;
    start_a = 1'b1;
    run_block(1'b0, 64'h0123456789ABCDEF, 0, -1, '0, 1'b0, '0, "blk1");

    // Start mid-transmission is ignored; start in the done cycle chains a new block
    data_in = 64'h0123456789ABCDEF;
    start_a = 1'b1;
    run_block(1'b0, 64'h0123456789ABCDEF, 0, 50, 64'hDEADBEEFCAFEF00D,
              1'b1, 64'hFFFF0000FFFF0000, "blk2");
    run_block(1'b0, 64'hFFFF0000FFFF0000, 0, -1, '0, 1'b0, '0, "blk3");

    // Async reset in the middle of byte 3 (data bit 2 of 0x89 = 0 on the line)
    data_in = 64'h0123456789ABCDEF;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (135) @(negedge clk);
    check("rst_mid", "tx_before", tx_a, 0);
    check("rst_mid", "idx_before", idx_a, 3);
    #1 rst = 1'b1;
    #1;
    check("rst_mid", "tx_async", tx_a, 1);
    check("rst_mid", "busy", busy_a, 0);
    check("rst_mid", "done", done_a, 0);
    check("rst_mid", "idx", idx_a, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) idle_ok = 1'b0;
    end
    check("rst_mid", "quiet_after", idle_ok, 1);
    data_in = 64'h0123456789ABCDEF;
    start_a = 1'b1;
    run_block(1'b0, 64'h0123456789ABCDEF, 0, -1, '0, 1'b0, '0, "blk4");

    // Two gap bits per frame on the second instance
    data_in = 64'h5555555555555555;
    start_b = 1'b1;
    run_block(1'b1, 64'h5555555555555555, 2, -1, '0, 1'b0, '0, "gap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
